bus_copy: RTL
=============

BUS_COPY -- requirements
Module: bus_copy

Interface
REQ-001 Parameter WIDTH, default 32, data word width of the bus in bits.
REQ-002 Parameter ADDR_STRIDE, default 4, byte increment of the address between consecutive words.
REQ-003 i_clock  input  1  single clock; all logic on rising edge.
REQ-004 i_reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 i_start  input  1  start a copy; sampled only in IDLE.
REQ-006 i_src  input  32  source byte address of first word.
REQ-007 i_dst  input  32  destination byte address of first word.
REQ-008 i_count  input  32  number of words to copy.
REQ-009 o_busy  output  1  high while a copy is in progress.
REQ-010 o_done  output  1  one-cycle completion pulse.
REQ-011 o_error  output  1  sticky; the last copy aborted on an invalid response.
REQ-012 o_request  output  1  bus request to the memory responder.
REQ-013 o_rw  output  1  0 = read, 1 = write.
REQ-014 o_address  output  32  bus byte address.
REQ-015 o_wdata  output  WIDTH  bus write data.
REQ-016 i_rdata  input  WIDTH  bus read data, valid when i_ready = 1.
REQ-017 i_ready  input  1  responder completion, sampled only while o_request = 1.
REQ-018 i_valid  input  1  responder address-valid flag, sampled with i_ready.

Function
REQ-019 States SHALL be IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE; all bus outputs and status outputs SHALL be registered.
REQ-020 In IDLE with i_start = 1, the block SHALL latch i_src, i_dst and i_count and clear o_error; it SHALL enter RD_REQ if count != 0, else DONE.
REQ-021 In IDLE, i_start = 0 SHALL leave the block in IDLE; while not IDLE, i_start SHALL be ignored.
REQ-022 RD_REQ: o_request = 1, o_rw = 0, o_address = current source; the outputs SHALL hold stable until i_ready = 1 is sampled.
REQ-023 On i_ready = 1 in RD_REQ with i_valid = 1, the block SHALL capture i_rdata into the write-data register, drop o_request and enter RD_GAP.
REQ-024 RD_GAP SHALL last exactly one cycle with o_request = 0; i_ready SHALL be ignored; the next state SHALL be WR_REQ.
REQ-025 WR_REQ: o_request = 1, o_rw = 1, o_address = current destination, o_wdata = captured word; the outputs SHALL hold until i_ready = 1.
REQ-026 On i_ready = 1 in WR_REQ with i_valid = 1, the block SHALL drop o_request, decrement the remaining count, advance both addresses by ADDR_STRIDE and enter WR_GAP.
REQ-027 WR_GAP SHALL last one cycle with i_ready ignored; the next state SHALL be RD_REQ if remaining != 0, else DONE.
REQ-028 Address increments SHALL wrap modulo 2^32 without error.
REQ-029 On i_ready = 1 with i_valid = 0 in RD_REQ or WR_REQ, the block SHALL drop o_request, set o_error = 1 and enter DONE; it SHALL issue no further requests, and a failed read SHALL issue no write.
REQ-030 DONE: o_done = 1 for exactly one cycle, o_busy = 0, and the next state SHALL be IDLE.
REQ-031 o_busy SHALL be 1 in RD_REQ, RD_GAP, WR_REQ and WR_GAP, and 0 otherwise.
REQ-032 With a responder whose i_ready follows o_request by one cycle, each word SHALL take 6 cycles: RD_REQ 2, RD_GAP 1, WR_REQ 2, WR_GAP 1.
REQ-033 o_done SHALL be high in the cycle after edge E0+6N for a copy of N words started at edge E0, and in the cycle after E0 for N = 0.
REQ-034 The block SHALL tolerate any responder latency of 1 or more cycles; it SHALL have no timeout.

Reset
REQ-035 While i_reset_n = 0, the state SHALL be IDLE and o_request, o_rw, o_busy, o_done and o_error SHALL be 0.
REQ-036 While i_reset_n = 0, o_address and o_wdata SHALL be 0, and the internal address and count registers SHALL be 0.
REQ-037 A reset asserted mid-copy SHALL drop o_request immediately (asynchronously), with no o_done pulse, and the copy SHALL NOT resume after release.

Verification
REQ-038 Single-latency BRAM model; src = 0x0 holds 0xA0..0xA3, dst = 0x100, count = 4 -> 0x100..0x10C = 0xA0..0xA3, o_done after E0+24, o_error = 0.
REQ-039 count = 0 -> no o_request ever asserted; o_done pulses in the cycle after the start edge.
REQ-040 Responder with i_ready delayed 5 cycles -> o_address, o_rw and o_wdata stable throughout the wait; one write per word; data correct.
REQ-041 dst beyond responder range (i_valid = 0 on first write) -> o_error = 1, o_done pulse, no second read; a new start clears o_error.
REQ-042 src = 0xFFFFFFFC, count = 2 -> second read address = 0x00000000.
REQ-043 i_reset_n low during WR_REQ of word 2 -> o_request = 0 at once, IDLE after release, no o_done; i_start pulsed while busy -> ignored.

Source files
------------

// File: rtl/bus_copy_if.sv
// Bus and control signals of the word-copy engine, grouped for the engine
// (master) and for the memory responder / controlling agent (slave).
interface bus_copy_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [31:0]      i_src;
   logic [31:0]      i_dst;
   logic [31:0]      i_count;
   logic             o_busy;
   logic             o_done;
   logic             o_error;

   // Handshake: the engine raises o_request with o_rw/o_address/o_wdata and
   // holds all of them stable until it samples i_ready = 1 on a rising edge;
   // i_valid and i_rdata are only meaningful in that same cycle, and the
   // engine always drops o_request for at least one cycle between transfers.
   logic             o_request;
   logic             o_rw;
   logic [31:0]      o_address;
   logic [WIDTH-1:0] o_wdata;
   logic [WIDTH-1:0] i_rdata;
   logic             i_ready;
   logic             i_valid;

   modport master (
      input  i_start, i_src, i_dst, i_count, i_rdata, i_ready, i_valid,
      output o_busy, o_done, o_error, o_request, o_rw, o_address, o_wdata
   );

   modport slave (
      output i_start, i_src, i_dst, i_count, i_rdata, i_ready, i_valid,
      input  o_busy, o_done, o_error, o_request, o_rw, o_address, o_wdata
   );
endinterface

// File: rtl/bus_copy.sv
// Word-by-word memory copy engine: read one word from the source address,
// write it to the destination address, repeat for the requested count.
module bus_copy #(
   parameter int WIDTH       = 32,
   parameter int ADDR_STRIDE = 4
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   bus_copy_if.master    bus,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_REQ = 3'd1,
      RD_GAP = 3'd2,
      WR_REQ = 3'd3,
      WR_GAP = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);

   state_t           state;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [31:0]      remaining;
   logic             request_q;
   logic             rw_q;
   logic [31:0]      address_q;
   logic [WIDTH-1:0] wdata_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         src_addr  <= '0;
         dst_addr  <= '0;
         remaining <= '0;
         request_q <= 1'b0;
         rw_q      <= 1'b0;
         address_q <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  src_addr  <= bus.i_src;
                  dst_addr  <= bus.i_dst;
                  remaining <= bus.i_count;
                  error_q   <= 1'b0;
                  if (bus.i_count != 32'd0) begin
                     state     <= RD_REQ;
                     request_q <= 1'b1;
                     rw_q      <= 1'b0;
                     address_q <= bus.i_src;
                     busy_q    <= 1'b1;
                  end else begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
            end

            RD_REQ: begin
               if (bus.i_ready) begin
                  request_q <= 1'b0;
                  if (bus.i_valid) begin
                     wdata_q <= bus.i_rdata;
                     state   <= RD_GAP;
                  end else begin
                     // An invalid read aborts before any write is issued.
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state   <= DONE;
                  end
               end
            end

            RD_GAP: begin
               state     <= WR_REQ;
               request_q <= 1'b1;
               rw_q      <= 1'b1;
               address_q <= dst_addr;
            end

            WR_REQ: begin
               if (bus.i_ready) begin
                  request_q <= 1'b0;
                  if (bus.i_valid) begin
                     remaining <= remaining - 32'd1;
                     src_addr  <= src_addr + STRIDE;
                     dst_addr  <= dst_addr + STRIDE;
                     state     <= WR_GAP;
                  end else begin
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state   <= DONE;
                  end
               end
            end

            WR_GAP: begin
               if (remaining != 32'd0) begin
                  state     <= RD_REQ;
                  request_q <= 1'b1;
                  rw_q      <= 1'b0;
                  address_q <= src_addr;
               end else begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state     <= IDLE;
               request_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_request = request_q;
   assign bus.o_rw      = rw_q;
   assign bus.o_address = address_q;
   assign bus.o_wdata   = wdata_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_done    = done_q;
   assign bus.o_error   = error_q;
   assign dbg_state     = state;

endmodule
